add_pipelined: RTL and testbench

ADD_PIPELINED -- requirements
Module: add_pipelined

---
 rtl/add_pipelined.sv | 134 +++++++++++++
 tb/tb_add_pipelined.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_pipelined.sv
// add_pipelined: carry-chunked pipelined adder with valid/ready handshake.
//
// The WIDTH-bit add is split into STAGES chunks of CHUNK = WIDTH/STAGES bits.
// Stage k adds operand chunk k plus the carry registered by stage k-1, and
// appends its chunk to the partial sum built up by the earlier stages. Operand
// bits that later stages still need travel alongside in delay registers. A
// single advance enable moves the whole pipeline, so bubbles are kept in
// place rather than squeezed out.
//
// WIDTH must be an exact multiple of STAGES.
//
// Ports:
//   clk        clock, all state on its rising edge
//   rst_n      synchronous active-low reset
//   in0, in1   operands (WIDTH bits)
//   carry_in   carry into bit 0
//   in_valid   operands hold a transaction
//   in_ready   transaction is accepted this cycle (equals advance enable)
//   sum        result bits [WIDTH-1:0]
//   carry_out  carry out of bit WIDTH-1
//   overflow   two's-complement signed overflow
//   out_valid  sum/carry_out/overflow hold a result
//   out_ready  downstream takes the result this cycle
module add_pipelined #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             carry_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES-1:0] valid_q;
  logic              adv;

  // The whole pipeline moves as one; it only stops when the last stage holds
  // a result that downstream is not taking.
  assign adv      = !valid_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q <= (valid_q << 1) | STAGES'(in_valid);
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Operand bits not yet consumed on entry to this stage; the low CHUNK
    // bits are the chunk added here.
    localparam int REM = WIDTH - k * CHUNK;

    logic [REM-1:0]           a_src;
    logic [REM-1:0]           b_src;
    logic                     c_src;
    logic [CHUNK:0]           part;
    logic [(k+1)*CHUNK-1:0]   r_next;
    logic [(k+1)*CHUNK-1:0]   r_q;
    logic                     c_q;

    if (k == 0) begin : g_first
      assign a_src  = in0;
      assign b_src  = in1;
      assign c_src  = carry_in;
      assign r_next = part[CHUNK-1:0];
    end else begin : g_next
      assign a_src  = g_stage[k-1].g_fwd.a_q;
      assign b_src  = g_stage[k-1].g_fwd.b_q;
      assign c_src  = g_stage[k-1].c_q;
      assign r_next = {part[CHUNK-1:0], g_stage[k-1].r_q};
    end

    assign part = {1'b0, a_src[CHUNK-1:0]} + {1'b0, b_src[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, c_src};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        r_q <= r_next;
        c_q <= part[CHUNK];
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      // Upper operand chunks delayed so the next stage sees the same
      // transaction as the partial sum it receives.
      logic [REM-CHUNK-1:0] a_q;
      logic [REM-CHUNK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_src[REM-1:CHUNK];
          b_q <= b_src[REM-1:CHUNK];
        end
      end
    end else begin : g_last
      // The last stage sees the operand sign bits and the final sum MSB
      // together, so overflow is registered here alongside the result.
      logic ovf_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= (a_src[CHUNK-1] == b_src[CHUNK-1]) &&
                   (part[CHUNK-1] != a_src[CHUNK-1]);
        end
      end
    end
  end

  assign sum       = g_stage[STAGES-1].r_q;
  assign carry_out = g_stage[STAGES-1].c_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;
  assign out_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_add_pipelined.sv
// Bench for add_pipelined: three builds (STAGES = 4, 1, 16, WIDTH = 16) share
// one stimulus stream. Each build has its own scoreboard fed from its own
// handshakes and checked against a plain-arithmetic model.
module tb_add_pipelined;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      in0, in1;
  logic             carry_in, in_valid, out_ready;
  logic [2:0]       ir, ov, cy, of;
  logic [2:0][15:0] sm;

  int n_pass   = 0;
  int n_checks = 0;

  // index: 0 -> STAGES=4, 1 -> STAGES=1, 2 -> STAGES=16
  int          lat [3] = '{4, 1, 16};
  logic [17:0] exp_q [3][$];
  int          n_out [3];
  logic        prev_stall [3];
  logic [17:0] prev_val [3];

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  add_pipelined #(.WIDTH(16), .STAGES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(ir[0]), .sum(sm[0]), .carry_out(cy[0]),
    .overflow(of[0]), .out_valid(ov[0]), .out_ready(out_ready)
  );

  add_pipelined #(.WIDTH(16), .STAGES(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(ir[1]), .sum(sm[1]), .carry_out(cy[1]),
    .overflow(of[1]), .out_valid(ov[1]), .out_ready(out_ready)
  );

  add_pipelined #(.WIDTH(16), .STAGES(16)) u_s16 (
    .clk(clk), .rst_n(rst_n), .in0(in0), .in1(in1), .carry_in(carry_in),
    .in_valid(in_valid), .in_ready(ir[2]), .sum(sm[2]), .carry_out(cy[2]),
    .overflow(of[2]), .out_valid(ov[2]), .out_ready(out_ready)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // Reference: {carry_out, overflow, sum} from integer addition.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    int unsigned full;
    logic        s15;
    logic        ovf;
    full = int'(a) + int'(b) + int'(c);
    s15  = full[15];
    ovf  = (a[15] == b[15]) && (s15 != a[15]);
    return {full[16], ovf, full[15:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards and stall-stability monitors, sampled mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        exp_q[d].delete();
      end else begin
        if (prev_stall[d])
          check("stall_hold_outputs", {ov[d], cy[d], of[d], sm[d]}, {1'b1, prev_val[d]});
        if (ov[d] && out_ready) begin
          check("sb_result_expected", exp_q[d].size() != 0, 1);
          if (exp_q[d].size() != 0) begin
            logic [17:0] e;
            e = exp_q[d].pop_front();
            check("sb_result", {cy[d], of[d], sm[d]}, e);
            n_out[d]++;
          end
        end
        if (in_valid && ir[d]) exp_q[d].push_back(model(in0, in1, carry_in));
      end
      prev_stall[d] = rst_n && ov[d] && !out_ready;
      prev_val[d]   = {cy[d], of[d], sm[d]};
    end
  end

  initial begin
    int          idx, stall_cnt, first [3];
    logic        seen;
    logic [17:0] held;

    tbl[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[4]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[5]  = '{16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0};
    tbl[6]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    tbl[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    tbl[8]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[9]  = '{16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[10] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    tbl[11] = '{16'h00F0, 16'h000F, 1'b1, 16'h0100, 1'b0, 1'b0};

    for (int d = 0; d < 3; d++) n_out[d] = 0;

    // Reset state
    rst_n = 1'b0; in0 = '0; in1 = '0; carry_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    check("rst_in_ready", ir, 3'b111);
    check("rst_out_valid", ov, 3'b000);
    check("rst_sum", sm[0], 16'h0000);
    check("rst_flags", {cy, of}, 6'b0);
    rst_n = 1'b1;
    step();
    step();

    // Directed vectors, back-to-back on the STAGES=4 build
    for (int j = 0; j < NV + 5; j++) begin
      logic ev;
      ev = (j >= 4) && (j - 4 < NV);
      check("tbl_out_valid", ov[0], ev);
      if (ev) begin
        check("tbl_sum", sm[0], tbl[j-4].s);
        check("tbl_carry_out", cy[0], tbl[j-4].co);
        check("tbl_overflow", of[0], tbl[j-4].ovf);
      end
      if (j < NV) begin
        in_valid = 1'b1; in0 = tbl[j].a; in1 = tbl[j].b; carry_in = tbl[j].c;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    repeat (20) step();

    // Latency of each build with no stall
    for (int d = 0; d < 3; d++) first[d] = -1;
    for (int j = 0; j < 22; j++) begin
      for (int d = 0; d < 3; d++)
        if (ov[d] && first[d] < 0) first[d] = j;
      in_valid = (j == 0); in0 = 16'h1234; in1 = 16'h4321; carry_in = 1'b0;
      step();
    end
    for (int d = 0; d < 3; d++) check("latency", first[d], lat[d]);

    // Six streamed transactions with a 3-cycle downstream stall
    n_out[0] = 0; idx = 0; stall_cnt = 0; seen = 1'b0; held = '0;
    for (int j = 0; j < 30; j++) begin
      if (ov[0] && !seen) begin
        seen = 1'b1; stall_cnt = 3; held = {cy[0], of[0], sm[0]};
      end
      out_ready = (stall_cnt == 0);
      if (idx < 6) begin
        in_valid = 1'b1;
        in0 = 16'h0FFF + 16'(idx * 16'h2345);
        in1 = 16'hF001 - 16'(idx * 16'h0111);
        carry_in = idx[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_cnt > 0) begin
        check("stall_in_ready", ir[0], 1'b0);
        check("stall_frozen", {ov[0], cy[0], of[0], sm[0]}, {1'b1, held});
        stall_cnt--;
      end
      if (in_valid && ir[0]) idx++;
      step();
    end
    check("stall_all_accepted", idx, 6);
    check("stall_delivered", n_out[0], 6);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) step();

    // Reset with three transactions in flight
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in0 = 16'h1111 * 16'(j + 1); in1 = 16'h0F0F; carry_in = 1'b1;
      step();
    end
    rst_n = 1'b0; in_valid = 1'b1; in0 = 16'hABCD; in1 = 16'h0001;
    #1;
    check("rst_mid_in_ready", ir, 3'b111);
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    check("rst_mid_out_valid", ov, 3'b000);
    check("rst_mid_sum", sm[0], 16'h0000);
    check("rst_mid_flags", {cy, of}, 6'b0);
    for (int j = 0; j < 20; j++) begin
      if (ov != 3'b000) check("no_stale_result", ov, 3'b000);
      step();
    end
    check("rst_mid_quiet", ov, 3'b000);

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      in0 = 16'($urandom);
      in1 = 16'($urandom);
      if ($urandom_range(3) == 0) in1 = ~in0;
      carry_in = 1'($urandom_range(1));
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (24) step();
    for (int d = 0; d < 3; d++) check("drain_empty", exp_q[d].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
